decode_branch_unit: RTL and testbench

Decode-stage branch/jump resolution unit for the MIPS pipeline, the parametrised successor to the plain decode-stage branch adder. It resolves all control-transfer instructions. It computes the target for BEQ, BNE, J, JAL, JR and JALR, decides taken/not-taken and produces the JAL/JALR link address, all registered. It also sequences a counted pipeline-flush window after every taken transfer. It sits between the decode logic and the fetch PC mux.

---
 rtl/decode_branch_unit.sv | 160 ++++++++++++++++
 tb/tb_decode_branch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_branch_unit.sv
// Decode-stage branch/jump resolution: target, taken decision, link address and flush window.
// Optional statistics counters are enabled by defining DECODE_BRANCH_STATS_EN.
module decode_branch_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMM_WIDTH    = 16,
    parameter int JADDR_WIDTH  = 26,
    parameter int FLUSH_CYCLES = 1,
    parameter int STAT_WIDTH   = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_stall,
    input  logic [2:0]             i_branch_op,
    input  logic [DATA_WIDTH-1:0]  i_currentpc,
    input  logic [IMM_WIDTH-1:0]   i_imm,
    input  logic [JADDR_WIDTH-1:0] i_jaddr,
    input  logic [DATA_WIDTH-1:0]  i_rs_data,
    input  logic [DATA_WIDTH-1:0]  i_rt_data,
    output logic                   o_take,
    output logic [DATA_WIDTH-1:0]  o_pc_target,
    output logic                   o_link_we,
    output logic [DATA_WIDTH-1:0]  o_link_addr,
    output logic                   o_flush,
    output logic                   o_busy
`ifdef DECODE_BRANCH_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]  o_branch_count,
    output logic [STAT_WIDTH-1:0]  o_taken_count
`endif
);

    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_BNE  = 3'd2;
    localparam logic [2:0] OP_J    = 3'd3;
    localparam logic [2:0] OP_JAL  = 3'd4;
    localparam logic [2:0] OP_JR   = 3'd5;
    localparam logic [2:0] OP_JALR = 3'd6;

    localparam logic [3:0]            FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] LINK_OFFSET = DATA_WIDTH'(32'd4);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                  state_r;
    logic [3:0]              count_r;
    logic [DATA_WIDTH-1:0]   imm_ext_s;
    logic [DATA_WIDTH-1:0]   target_s;
    logic                    taken_s;
    logic                    link_s;
    logic                    capture_s;

    assign capture_s = i_valid & ~i_stall & (state_r == ST_IDLE);

    // Target selection and taken/link decision for the op in decode
    always_comb begin
        imm_ext_s = {{(DATA_WIDTH-IMM_WIDTH){i_imm[IMM_WIDTH-1]}}, i_imm};
        target_s  = i_currentpc + {imm_ext_s[DATA_WIDTH-3:0], 2'b00};
        taken_s   = 1'b0;
        link_s    = 1'b0;
        case (i_branch_op)
            OP_BEQ: begin
                taken_s = (i_rs_data == i_rt_data);
            end
            OP_BNE: begin
                taken_s = (i_rs_data != i_rt_data);
            end
            OP_J, OP_JAL: begin
                target_s = {i_currentpc[DATA_WIDTH-1:JADDR_WIDTH+2], i_jaddr, 2'b00};
                taken_s  = 1'b1;
                link_s   = (i_branch_op == OP_JAL);
            end
            OP_JR, OP_JALR: begin
                target_s = i_rs_data;
                taken_s  = 1'b1;
                link_s   = (i_branch_op == OP_JALR);
            end
            default: begin
                taken_s = 1'b0;
                link_s  = 1'b0;
            end
        endcase
    end

    // Capture, output pulses and the counted flush window
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            count_r     <= 4'd0;
            o_take      <= 1'b0;
            o_link_we   <= 1'b0;
            o_flush     <= 1'b0;
            o_busy      <= 1'b0;
            o_pc_target <= {DATA_WIDTH{1'b0}};
            o_link_addr <= {DATA_WIDTH{1'b0}};
        end else begin
            o_take    <= 1'b0;
            o_link_we <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (capture_s) begin
                        o_pc_target <= target_s;
                        o_link_addr <= i_currentpc + LINK_OFFSET;
                        o_take      <= taken_s;
                        o_link_we   <= link_s;
                        if (taken_s) begin
                            state_r <= ST_FLUSH;
                            count_r <= FLUSH_LOAD;
                            o_flush <= 1'b1;
                            o_busy  <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Stall does not hold the window; it always drains
                    if (count_r == 4'd0) begin
                        state_r <= ST_IDLE;
                        o_flush <= 1'b0;
                        o_busy  <= 1'b0;
                    end else begin
                        count_r <= count_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= 4'd0;
                    o_flush <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DECODE_BRANCH_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

    logic branch_op_s;
    assign branch_op_s = (i_branch_op != 3'd0) && (i_branch_op != 3'd7);

    // Saturating capture statistics
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_branch_count <= {STAT_WIDTH{1'b0}};
            o_taken_count  <= {STAT_WIDTH{1'b0}};
        end else begin
            if (capture_s && branch_op_s && (o_branch_count != STAT_MAX)) begin
                o_branch_count <= o_branch_count + STAT_ONE;
            end
            if (capture_s && taken_s && (o_taken_count != STAT_MAX)) begin
                o_taken_count <= o_taken_count + STAT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_branch_unit.sv
// Self-checking bench for decode_branch_unit: directed vector table, hand sequences and
// randomized traffic against a cycle-level reference model, on FLUSH_CYCLES=1 and =3 instances.
module tb_decode_branch_unit;

    localparam int F_A  = 1;
    localparam int F_B  = 3;
    localparam int SW_A = 2;
    localparam int SW_B = 16;

    logic        clk = 1'b0;
    logic        i_reset, i_valid, i_stall;
    logic [2:0]  i_branch_op;
    logic [31:0] i_currentpc, i_rs_data, i_rt_data;
    logic [15:0] i_imm;
    logic [25:0] i_jaddr;

    logic        a_take, a_link_we, a_flush, a_busy;
    logic [31:0] a_pc_target, a_link_addr;
    logic        b_take, b_link_we, b_flush, b_busy;
    logic [31:0] b_pc_target, b_link_addr;
`ifdef DECODE_BRANCH_STATS_EN
    logic [SW_A-1:0] a_branch_count, a_taken_count;
    logic [SW_B-1:0] b_branch_count, b_taken_count;
`endif

    always #5 clk = ~clk;

    decode_branch_unit #(.FLUSH_CYCLES(F_A), .STAT_WIDTH(SW_A)) u_dut_a (
        .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
        .i_branch_op(i_branch_op), .i_currentpc(i_currentpc), .i_imm(i_imm),
        .i_jaddr(i_jaddr), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .o_take(a_take), .o_pc_target(a_pc_target), .o_link_we(a_link_we),
        .o_link_addr(a_link_addr), .o_flush(a_flush), .o_busy(a_busy)
`ifdef DECODE_BRANCH_STATS_EN
        , .o_branch_count(a_branch_count), .o_taken_count(a_taken_count)
`endif
    );

    decode_branch_unit #(.FLUSH_CYCLES(F_B), .STAT_WIDTH(SW_B)) u_dut_b (
        .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
        .i_branch_op(i_branch_op), .i_currentpc(i_currentpc), .i_imm(i_imm),
        .i_jaddr(i_jaddr), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .o_take(b_take), .o_pc_target(b_pc_target), .o_link_we(b_link_we),
        .o_link_addr(b_link_addr), .o_flush(b_flush), .o_busy(b_busy)
`ifdef DECODE_BRANCH_STATS_EN
        , .o_branch_count(b_branch_count), .o_taken_count(b_taken_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = instance A, 1 = instance B
    int          rem[2];
    logic        e_take[2], e_lw[2];
    logic [31:0] e_tgt[2], e_la[2];
    logic        tgt_known[2], la_known[2];
    int          e_bc[2], e_tc[2];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] pc;
        logic [15:0] imm;
        logic [25:0] jaddr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        take;
        logic [31:0] tgt;
        logic        lw;
        logic [31:0] la;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_eval(input logic [2:0] op, input logic [31:0] pc,
                                     input logic [15:0] imm, input logic [25:0] ja,
                                     input logic [31:0] rs, input logic [31:0] rt,
                                     output logic tk, output logic lk, output logic [31:0] tg);
        int signed off;
        off = $signed(imm);
        tk = 1'b0;
        lk = 1'b0;
        tg = 32'h0;
        case (op)
            3'd1: begin tk = (rs == rt); tg = pc + 32'(off * 4); end
            3'd2: begin tk = (rs != rt); tg = pc + 32'(off * 4); end
            3'd3, 3'd4: begin
                tk = 1'b1;
                lk = (op == 3'd4);
                tg = (pc & 32'hF000_0000) | (32'(ja) << 2);
            end
            3'd5, 3'd6: begin tk = 1'b1; lk = (op == 3'd6); tg = rs; end
            default: begin tk = 1'b0; end
        endcase
    endfunction

    // One clock: predict both instances from current inputs, clock, then compare
    task automatic step();
        logic        tk, lk, cap;
        logic [31:0] tg;
        int          fl, mx;
        ref_eval(i_branch_op, i_currentpc, i_imm, i_jaddr, i_rs_data, i_rt_data, tk, lk, tg);
        for (int k = 0; k < 2; k++) begin
            fl = (k == 0) ? F_A : F_B;
            mx = (k == 0) ? (1 << SW_A) - 1 : (1 << SW_B) - 1;
            if (i_reset) begin
                rem[k] = 0; e_take[k] = 1'b0; e_lw[k] = 1'b0;
                e_tgt[k] = 32'h0; e_la[k] = 32'h0; tgt_known[k] = 1'b1; la_known[k] = 1'b1;
                e_bc[k] = 0; e_tc[k] = 0;
            end else begin
                cap = i_valid && !i_stall && (rem[k] == 0);
                e_take[k] = cap && tk;
                e_lw[k]   = cap && lk;
                if (cap) begin
                    tgt_known[k] = tk;
                    e_tgt[k]     = tg;
                    la_known[k]  = lk;
                    e_la[k]      = i_currentpc + 32'd4;
                    if (i_branch_op >= 3'd1 && i_branch_op <= 3'd6 && e_bc[k] < mx) e_bc[k]++;
                    if (tk && e_tc[k] < mx) e_tc[k]++;
                end
                if (rem[k] > 0) rem[k]--;
                else if (cap && tk) rem[k] = fl;
            end
        end
        @(posedge clk);
        #1;
        check("a_take", a_take, e_take[0]);
        check("a_link_we", a_link_we, e_lw[0]);
        check("a_flush", a_flush, rem[0] > 0);
        check("a_busy", a_busy, rem[0] > 0);
        if (tgt_known[0]) check("a_pc_target", a_pc_target, e_tgt[0]);
        if (la_known[0]) check("a_link_addr", a_link_addr, e_la[0]);
        check("b_take", b_take, e_take[1]);
        check("b_link_we", b_link_we, e_lw[1]);
        check("b_flush", b_flush, rem[1] > 0);
        check("b_busy", b_busy, rem[1] > 0);
        if (tgt_known[1]) check("b_pc_target", b_pc_target, e_tgt[1]);
        if (la_known[1]) check("b_link_addr", b_link_addr, e_la[1]);
`ifdef DECODE_BRANCH_STATS_EN
        check("a_branch_count", 32'(a_branch_count), e_bc[0]);
        check("a_taken_count", 32'(a_taken_count), e_tc[0]);
        check("b_branch_count", 32'(b_branch_count), e_bc[1]);
        check("b_taken_count", 32'(b_taken_count), e_tc[1]);
`endif
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] imm,
                         input logic [25:0] ja, input logic [31:0] rs, input logic [31:0] rt);
        i_branch_op = op; i_currentpc = pc; i_imm = imm; i_jaddr = ja;
        i_rs_data = rs; i_rt_data = rt; i_valid = 1'b1; i_stall = 1'b0;
    endtask

    task automatic wait_idle();
        i_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rem[0] == 0 && rem[1] == 0) break;
            step();
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_valid = 1'b0; i_stall = 1'b0;
        step();
        step();
        i_reset = 1'b0;
    endtask

    initial begin
        int run;
        tbl[0] = '{3'd1, 32'h0000_0104, 16'hFFFE, 26'h0, 32'd5, 32'd5, 1'b1, 32'h0000_00FC, 1'b0, 32'h0};
        tbl[1] = '{3'd2, 32'h0000_0200, 16'h0010, 26'h0, 32'd7, 32'd7, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[2] = '{3'd1, 32'h0000_0300, 16'h0004, 26'h0, 32'd1, 32'd2, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[3] = '{3'd2, 32'h0000_1000, 16'h0010, 26'h0, 32'd1, 32'd2, 1'b1, 32'h0000_1040, 1'b0, 32'h0};
        tbl[4] = '{3'd4, 32'h4000_0010, 16'h0, 26'h0000040, 32'h0, 32'h0, 1'b1, 32'h4000_0100, 1'b1, 32'h4000_0014};
        tbl[5] = '{3'd3, 32'h8000_0000, 16'h0, 26'h3FF_FFFF, 32'h0, 32'h0, 1'b1, 32'h8FFF_FFFC, 1'b0, 32'h0};
        tbl[6] = '{3'd5, 32'h0000_0040, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        tbl[7] = '{3'd6, 32'hFFFF_FFFC, 16'h0, 26'h0, 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0000};
        tbl[8] = '{3'd0, 32'h0000_0500, 16'h0001, 26'h1, 32'd3, 32'd3, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[9] = '{3'd7, 32'h0000_0600, 16'h0001, 26'h1, 32'd3, 32'd3, 1'b0, 32'h0, 1'b0, 32'h0};

        i_reset = 1'b0;
        drive(3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0);
        i_valid = 1'b0;
        do_reset();
        check("reset_take", a_take, 1'b0);
        check("reset_flush", b_flush, 1'b0);
        check("reset_target", a_pc_target, 32'h0);

        // Directed vector table on idle units
        for (int v = 0; v < 10; v++) begin
            drive(tbl[v].op, tbl[v].pc, tbl[v].imm, tbl[v].jaddr, tbl[v].rs, tbl[v].rt);
            step();
            check($sformatf("vec%0d_take", v), a_take, tbl[v].take);
            check($sformatf("vec%0d_link_we", v), a_link_we, tbl[v].lw);
            check($sformatf("vec%0d_flush", v), a_flush, tbl[v].take);
            if (tbl[v].take) check($sformatf("vec%0d_target", v), a_pc_target, tbl[v].tgt);
            if (tbl[v].lw) check($sformatf("vec%0d_link_addr", v), a_link_addr, tbl[v].la);
            wait_idle();
        end

        // Not-taken BNE followed immediately by a taken BEQ
        drive(3'd2, 32'h0000_0200, 16'h0010, 26'h0, 32'd7, 32'd7);
        step();
        drive(3'd1, 32'h0000_0104, 16'hFFFE, 26'h0, 32'd5, 32'd5);
        step();
        check("bne_then_beq_take", a_take, 1'b1);
        wait_idle();

        // JR with valid held: flush window length on the 3-cycle instance
        drive(3'd5, 32'h0000_0040, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0);
        step();
        check("jr_wrap_target", b_pc_target, 32'hFFFF_FFFC);
        run = 0;
        while (b_flush && run < 10) begin
            run++;
            step();
        end
        check("jr_flush_len", run, 32'd3);
        wait_idle();

        // Stall holds capture off, release lets it through
        drive(3'd3, 32'h0000_1000, 16'h0, 26'h0000123, 32'h0, 32'h0);
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_no_take", a_take, 1'b0);
        end
        i_stall = 1'b0;
        step();
        check("stall_release_take", a_take, 1'b1);
        wait_idle();

        // Reset in the middle of a flush window
        drive(3'd6, 32'h0000_2000, 16'h0, 26'h0, 32'h0000_3000, 32'h0);
        step();
        i_valid = 1'b0;
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("rst_mid_busy", b_busy, 1'b0);
        check("rst_mid_flush", b_flush, 1'b0);
        check("rst_mid_target", b_pc_target, 32'h0);
        check("rst_mid_link_addr", b_link_addr, 32'h0);
        drive(3'd4, 32'h4000_0010, 16'h0, 26'h0000040, 32'h0, 32'h0);
        step();
        check("post_rst_capture", b_take, 1'b1);
        wait_idle();

`ifdef DECODE_BRANCH_STATS_EN
        do_reset();
        drive(3'd1, 32'h100, 16'h4, 26'h0, 32'd1, 32'd1); step(); wait_idle();
        drive(3'd2, 32'h100, 16'h4, 26'h0, 32'd1, 32'd1); step(); wait_idle();
        drive(3'd3, 32'h100, 16'h0, 26'h10, 32'd0, 32'd0); step(); wait_idle();
        drive(3'd5, 32'h100, 16'h0, 26'h0, 32'h80, 32'd0); step(); wait_idle();
        check("stats_branch_count", 32'(b_branch_count), 32'd4);
        check("stats_taken_count", 32'(b_taken_count), 32'd3);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3'd3, 32'h100, 16'h0, 26'(i), 32'd0, 32'd0);
            step();
            wait_idle();
        end
        check("stats_taken_sat", 32'(a_taken_count), 32'd3);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            i_reset     = ($urandom_range(0, 49) == 0);
            i_valid     = ($urandom_range(0, 3) != 0);
            i_stall     = ($urandom_range(0, 4) == 0);
            i_branch_op = 3'($urandom_range(0, 7));
            i_currentpc = $urandom;
            i_imm       = 16'($urandom);
            i_jaddr     = 26'($urandom);
            i_rs_data   = $urandom;
            i_rt_data   = ($urandom_range(0, 1) == 1) ? i_rs_data : $urandom;
            step();
        end
        i_reset = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
